cordic_phase_frontend: RTL and testbench

- Upstream stage for the CORDIC rotator: a numerically controlled oscillator (NCO) phase accumulator plus a range-reduction unit.
- Holds a 32-bit turn-fraction phase (2^32 = one full turn) and folds it into [-pi/2, pi/2).
- Converts the folded phase to a signed Q2.30 radian angle using a serial shift-add multiply by pi/2.
- Presents theta with a valid/ready handshake. A sideband flag tells the consumer to negate both cos and sin.

---
 rtl/cordic_pkg.sv | 23 ++
 rtl/cordic_serial_mult.sv | 61 ++++++
 rtl/cordic_phase_frontend.sv | 136 +++++++++++++
 tb/tb_cordic_phase_frontend.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC phase front end.
// Holds the phase/angle formats, the pi/2 multiplier constant and the front-end state encoding.
package cordic_pkg;

  // 32-bit turn fraction: 2^32 = one full turn.
  localparam int unsigned PHASE_W = 32;
  // Signed Q2.30 radian angle.
  localparam int unsigned ANGLE_W = 32;
  localparam int unsigned FRAC_W  = 30;
  // Magnitude of a folded phase in [-2^30, 2^30) fits in 31 bits.
  localparam int unsigned MAG_W   = 31;
  localparam int unsigned PROD_W  = 62;

  // round(pi/2 * 2^30), unsigned Q2.30.
  localparam logic [ANGLE_W-1:0] HALF_PI_Q30 = 32'h6487ED51;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StHold
  } fe_state_e;

endpackage

// File: rtl/cordic_serial_mult.sv
// Serial shift-add multiplier: 31-bit unsigned magnitude times a 32-bit constant.
// One multiplier bit per cycle, LSB first; exactly 31 cycles after the start edge.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   start_i   - launch strobe; samples mag_i on this edge
//   mag_i     - 31-bit unsigned multiplier
//   done_o    - product valid; stays high until the next start
//   prod_o    - 62-bit unsigned product
module cordic_serial_mult
  import cordic_pkg::*;
#(
  parameter logic [ANGLE_W-1:0] Coef = HALF_PI_Q30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [MAG_W-1:0]  mag_i,
  output logic              done_o,
  output logic [PROD_W-1:0] prod_o
);

  logic [MAG_W-1:0]  mplier_q;
  logic [PROD_W-1:0] addend_q;
  logic [PROD_W-1:0] acc_q;
  logic [4:0]        cnt_q;
  logic              run_q;
  logic              done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mplier_q <= '0;
      addend_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else if (start_i) begin
      mplier_q <= mag_i;
      addend_q <= {{(PROD_W - ANGLE_W){1'b0}}, Coef};
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b1;
      done_q   <= 1'b0;
    end else if (run_q) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + addend_q;
      end
      mplier_q <= mplier_q >> 1;
      addend_q <= addend_q << 1;
      cnt_q    <= cnt_q + 5'd1;
      if (cnt_q == 5'(MAG_W - 1)) begin
        run_q  <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign done_o = done_q;
  assign prod_o = acc_q;

endmodule

// File: rtl/cordic_phase_frontend.sv
// NCO phase accumulator plus range reduction feeding the CORDIC rotator.
// Folds the 32-bit turn-fraction phase into [-pi/2, pi/2), converts it to a signed Q2.30
// radian angle with a serial multiply by pi/2, and presents it on a valid/ready port.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   run_i             - free-run enable; new samples launch only while high
//   cfg_fcw_i         - frequency control word, added per delivered sample
//   cfg_phase_load_i  - strobe: overwrite the accumulator with cfg_phase_i
//   cfg_phase_i       - phase value to load
//   out_valid_o       - theta_o/negate_o valid
//   out_ready_i       - downstream accepts
//   theta_o           - signed Q2.30 angle in [-pi/2, pi/2)
//   negate_o          - consumer must negate both cos and sin
//   busy_o            - a sample is in flight (MUL or HOLD)
module cordic_phase_frontend
  import cordic_pkg::*;
#(
  parameter logic [ANGLE_W-1:0] HALF_PI  = HALF_PI_Q30,
  parameter bit                 ROUND_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run_i,
  input  logic [PHASE_W-1:0] cfg_fcw_i,
  input  logic               cfg_phase_load_i,
  input  logic [PHASE_W-1:0] cfg_phase_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [ANGLE_W-1:0] theta_o,
  output logic               negate_o,
  output logic               busy_o
);

  localparam logic signed [63:0] RoundBias = 64'sh0000_0000_2000_0000;

  fe_state_e          state_q;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               out_valid_q, negate_q;
  logic [ANGLE_W-1:0] theta_q, theta_d;
  logic               sign_q, neg_pend_q;

  logic               handshake, launch;
  logic [PHASE_W-1:0] launch_ph, folded;
  logic               fold_neg, fold_sign;
  logic [MAG_W-1:0]   fold_mag;

  logic               mult_done;
  logic [PROD_W-1:0]  prod;
  logic [63:0]        prod_ext;
  logic signed [63:0] prod_s, rounded, shifted;
  logic               unused_bits;

  always_comb begin
    handshake = (state_q == StHold) & out_ready_i;
    // A load always wins over the per-sample increment.
    if (cfg_phase_load_i) begin
      phase_d = cfg_phase_i;
    end else if (handshake) begin
      phase_d = phase_q + cfg_fcw_i;
    end else begin
      phase_d = phase_q;
    end

    launch    = run_i & ((state_q == StIdle) | handshake);
    // Back-to-back launches use the phase the accumulator is about to hold.
    launch_ph = (state_q == StIdle) ? phase_q : phase_d;

    // Outside [-1/4, 1/4) turn: rotate by half a turn and flag the consumer to negate.
    fold_neg  = launch_ph[31] ^ launch_ph[30];
    folded    = {launch_ph[31] ^ fold_neg, launch_ph[30:0]};
    fold_sign = folded[31];
    fold_mag  = fold_sign ? (~folded[MAG_W-1:0] + 31'd1) : folded[MAG_W-1:0];

    prod_ext    = {2'b00, prod};
    prod_s      = sign_q ? -$signed(prod_ext) : $signed(prod_ext);
    rounded     = prod_s + (ROUND_EN ? RoundBias : 64'sd0);
    shifted     = rounded >>> FRAC_W;
    theta_d     = shifted[ANGLE_W-1:0];
    unused_bits = ^shifted[63:ANGLE_W];
  end

  cordic_serial_mult #(
    .Coef(HALF_PI)
  ) u_mult (
    .clk    (clk),
    .rst    (rst),
    .start_i(launch),
    .mag_i  (fold_mag),
    .done_o (mult_done),
    .prod_o (prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      phase_q     <= '0;
      out_valid_q <= 1'b0;
      theta_q     <= '0;
      negate_q    <= 1'b0;
      sign_q      <= 1'b0;
      neg_pend_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      if (launch) begin
        sign_q     <= fold_sign;
        neg_pend_q <= fold_neg;
      end
      unique case (state_q)
        StIdle: begin
          if (run_i) state_q <= StMul;
        end
        StMul: begin
          if (mult_done) begin
            state_q     <= StHold;
            out_valid_q <= 1'b1;
            theta_q     <= theta_d;
            negate_q    <= neg_pend_q;
          end
        end
        StHold: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= run_i ? StMul : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign theta_o     = theta_q;
  assign negate_o    = negate_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_cordic_phase_frontend.sv
// Bench for cordic_phase_frontend: a rounding and a truncating instance share the stimulus and
// are checked every cycle against a sample-level model, plus literal expectations.
module tb_cordic_phase_frontend;

  localparam longint HP = 64'h6487ED51;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [31:0] cfg_fcw;
  logic        cfg_phase_load;
  logic [31:0] cfg_phase;
  logic        out_ready;

  logic        out_valid, negate, busy;
  logic [31:0] theta;
  logic        out_valid_t, negate_t, busy_t;
  logic [31:0] theta_t;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cordic_phase_frontend #(
    .ROUND_EN(1'b1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .run_i           (run),
    .cfg_fcw_i       (cfg_fcw),
    .cfg_phase_load_i(cfg_phase_load),
    .cfg_phase_i     (cfg_phase),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .theta_o         (theta),
    .negate_o        (negate),
    .busy_o          (busy)
  );

  cordic_phase_frontend #(
    .ROUND_EN(1'b0)
  ) dut_t (
    .clk             (clk),
    .rst             (rst),
    .run_i           (run),
    .cfg_fcw_i       (cfg_fcw),
    .cfg_phase_load_i(cfg_phase_load),
    .cfg_phase_i     (cfg_phase),
    .out_valid_o     (out_valid_t),
    .out_ready_i     (out_ready),
    .theta_o         (theta_t),
    .negate_o        (negate_t),
    .busy_o          (busy_t)
  );

  // Sample-level model: a sample in flight becomes visible 32 edges after its launch.
  bit          m_busy, m_valid;
  int          m_cnt;
  logic [31:0] m_phase;
  longint      m_p, m_p_out;
  logic        m_neg_pend, m_neg;
  logic [31:0] m_exp, m_exp_t, m_theta, m_theta_t;

  task automatic model_launch(input logic [31:0] ph);
    logic [31:0] f;
    f          = (ph[31] == ph[30]) ? ph : ph - 32'h8000_0000;
    m_p        = longint'($signed(f));
    m_neg_pend = (ph[31] != ph[30]);
    m_exp      = 32'((m_p * HP + 64'sd536870912) >>> 30);
    m_exp_t    = 32'((m_p * HP) >>> 30);
    m_busy     = 1'b1;
    m_cnt      = 0;
  endtask

  always @(posedge clk or posedge rst) begin : model
    logic        hs;
    logic [31:0] nph;
    if (rst) begin
      m_busy = 0; m_valid = 0; m_cnt = 0; m_phase = '0;
      m_theta = '0; m_theta_t = '0; m_neg = 1'b0; m_p_out = 0;
    end else begin
      hs  = m_valid && out_ready;
      nph = cfg_phase_load ? cfg_phase : (hs ? m_phase + cfg_fcw : m_phase);
      if (!m_busy) begin
        if (run) model_launch(m_phase);
      end else if (m_valid) begin
        if (hs) begin
          m_valid = 0;
          if (run) model_launch(nph);
          else m_busy = 0;
        end
      end else begin
        m_cnt++;
        if (m_cnt == 32) begin
          m_valid   = 1;
          m_theta   = m_exp;
          m_theta_t = m_exp_t;
          m_neg     = m_neg_pend;
          m_p_out   = m_p;
        end
      end
      m_phase = nph;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic compare_loop();
    logic prev_v = 1'b0;
    real  err;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("out_valid", out_valid, m_valid);
        chk("busy", busy, m_busy);
        chk("theta", theta, m_theta);
        chk("negate", negate, m_neg);
        chk("out_valid_trunc", out_valid_t, m_valid);
        chk("busy_trunc", busy_t, m_busy);
        chk("theta_trunc", theta_t, m_theta_t);
        chk("negate_trunc", negate_t, m_neg);
        if (out_valid && !prev_v) begin
          err = $itor($signed(theta)) - $itor(m_p_out) * 3.141592653589793 / 2.0;
          if (err < 0.0) err = -err;
          checks++;
          if (err > 1.000001) begin
            errors++;
            $display("FAIL theta_vs_real: got %0d, error %f LSB, allowed 1", $signed(theta), err);
          end
        end
        prev_v = out_valid;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic get_sample(input string nm, output logic [31:0] th, output logic ng);
    int n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    chk({nm, "_timeout"}, out_valid, 1);
    th = theta;
    ng = negate;
  endtask

  initial begin
    logic [31:0] th, th0;
    logic        ng, ng0, stable;
    logic [31:0] exp_th[5];
    logic        exp_ng[5];
    int          n;

    exp_th = '{32'h0, 32'h9B7812AF, 32'h0, 32'h9B7812AF, 32'h0};
    exp_ng = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; run = 1'b0; cfg_fcw = '0; cfg_phase_load = 1'b0; cfg_phase = '0;
    out_ready = 1'b1;
    fork
      compare_loop();
    join_none

    repeat (3) tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_theta", theta, 0);
    chk("rst_negate", negate, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // pi/4 with latency measurement.
    cfg_phase = 32'h2000_0000; cfg_phase_load = 1'b1;
    tick();
    cfg_phase_load = 1'b0; run = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 100);
    chk("latency_edges", n, 33);
    chk("pi4_theta", theta, 843314857);
    chk("pi4_theta_trunc", theta_t, 843314856);
    chk("pi4_negate", negate, 0);
    run = 1'b0;
    tick();

    // Quarter-turn steps around the circle, including the wrap.
    cfg_phase = '0; cfg_phase_load = 1'b1; cfg_fcw = 32'h4000_0000;
    tick();
    cfg_phase_load = 1'b0; run = 1'b1;
    for (int k = 0; k < 5; k++) begin
      get_sample("quarter", th, ng);
      chk($sformatf("quarter%0d_theta", k), th, exp_th[k]);
      chk($sformatf("quarter%0d_negate", k), ng, exp_ng[k]);
      if (k == 4) run = 1'b0;
      tick();
    end

    // Backpressure: outputs hold, accumulator waits for the handshake.
    out_ready = 1'b0; cfg_phase = 32'h2000_0000; cfg_phase_load = 1'b1; cfg_fcw = 32'h2000_0000;
    tick();
    cfg_phase_load = 1'b0; run = 1'b1;
    get_sample("bp_first", th0, ng0);
    stable = 1'b1;
    repeat (50) begin
      tick();
      if (theta !== th0 || negate !== ng0 || out_valid !== 1'b1) stable = 1'b0;
    end
    chk("bp_hold_stable", stable, 1);
    out_ready = 1'b1;
    tick();
    get_sample("bp_next", th, ng);
    chk("bp_next_theta", th, 32'h9B7812AF);
    chk("bp_next_negate", ng, 1);
    run = 1'b0;
    tick();

    // Load coinciding with the handshake wins over the increment.
    out_ready = 1'b0; cfg_phase = 32'h1000_0000; cfg_phase_load = 1'b1; cfg_fcw = 32'h1000_0000;
    tick();
    cfg_phase_load = 1'b0; run = 1'b1;
    get_sample("ld_first", th, ng);
    cfg_phase = 32'hC000_0000; cfg_phase_load = 1'b1; out_ready = 1'b1;
    tick();
    cfg_phase_load = 1'b0;
    get_sample("ld_next", th, ng);
    chk("ld_next_theta", th, 32'h9B7812AF);
    chk("ld_next_negate", ng, 0);
    run = 1'b0;
    tick();

    // Reset ten cycles into MUL.
    run = 1'b1;
    repeat (11) tick();
    rst = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_theta", theta, 0);
    chk("midrst_busy", busy, 0);
    tick();
    rst = 1'b0;
    get_sample("restart", th, ng);
    chk("restart_theta", th, 0);
    chk("restart_negate", ng, 0);
    run = 1'b0;
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      run            = ($urandom_range(0, 7) != 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      cfg_phase_load = ($urandom_range(0, 15) == 0);
      cfg_phase      = $urandom;
      if ($urandom_range(0, 7) == 0) cfg_fcw = $urandom;
      tick();
    end
    run = 1'b0; out_ready = 1'b1; cfg_phase_load = 1'b0;
    repeat (80) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
